// File: rtl/adder_seq_chunked_if.sv
// rtl/adder_seq_chunked_if.sv - request/result bundle for the chunked sequential adder
interface adder_seq_chunked_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, ci, sub,
    input  busy, done, s, co, ovf, zero
  );

  modport slave (
    input  start, a, b, ci, sub,
    output busy, done, s, co, ovf, zero
  );
endinterface

// File: rtl/adder_seq_chunked.sv
// rtl/adder_seq_chunked.sv - multi-cycle ripple adder/subtractor, one CHUNK-bit slice per clock
module adder_seq_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  adder_seq_chunked_if.slave   bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   sl_full;
  logic             last_sl;

  // Operands shift right each cycle so the active slice is always at bit 0.
  assign a_sl    = a_q[CHUNK-1:0];
  assign b_sl    = b_q[CHUNK-1:0];
  assign sl_full = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  assign last_sl = (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ^ bus.ci;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q*CHUNK +: CHUNK] = sl_full[CHUNK-1:0];
        carry_d = sl_full[CHUNK];
        idx_d   = idx_q + IW'(1);
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        if (last_sl) begin
          co_d    = sl_full[CHUNK];
          // carry into the MSB recovered as sum ^ a ^ b at that bit
          ovf_d   = sl_full[CHUNK] ^ sl_full[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
          zero_d  = (s_d == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_adder_seq_chunked.sv
// tb/tb_adder_seq_chunked.sv - vector table, scoreboard and parameter sweep for adder_seq_chunked
module tb_adder_seq_chunked;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int WW[4] = '{32, 32, 32, 8};
  localparam int NN[4] = '{8, 1, 32, 4};

  adder_seq_chunked_if #(.WIDTH(32)) if0 ();
  adder_seq_chunked_if #(.WIDTH(32)) if1 ();
  adder_seq_chunked_if #(.WIDTH(32)) if2 ();
  adder_seq_chunked_if #(.WIDTH(8))  if3 ();

  adder_seq_chunked #(.WIDTH(32), .CHUNK(4))  dut0 (.clk(clk), .reset(reset), .bus(if0));
  adder_seq_chunked #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  adder_seq_chunked #(.WIDTH(32), .CHUNK(1))  dut2 (.clk(clk), .reset(reset), .bus(if2));
  adder_seq_chunked #(.WIDTH(8),  .CHUNK(2))  dut3 (.clk(clk), .reset(reset), .bus(if3));

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
  } sb_t;

  typedef struct {
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } obs_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    logic [63:0] mask, aa, bb, full;
    exp_t r;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b};
    if (sub) bb = ~bb;
    bb   = bb & mask;
    full = aa + bb + {63'd0, ci ^ sub};
    r.s    = full[31:0] & mask[31:0];
    r.co   = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  task automatic drive(input int k, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub);
    case (k)
      0: begin if0.start = st; if0.a = a; if0.b = b; if0.ci = ci; if0.sub = sub; end
      1: begin if1.start = st; if1.a = a; if1.b = b; if1.ci = ci; if1.sub = sub; end
      2: begin if2.start = st; if2.a = a; if2.b = b; if2.ci = ci; if2.sub = sub; end
      default: begin if3.start = st; if3.a = a[7:0]; if3.b = b[7:0]; if3.ci = ci; if3.sub = sub; end
    endcase
  endtask

  function automatic obs_t peek(input int k);
    obs_t o;
    case (k)
      0: o = '{if0.busy, if0.done, if0.s, if0.co, if0.ovf, if0.zero};
      1: o = '{if1.busy, if1.done, if1.s, if1.co, if1.ovf, if1.zero};
      2: o = '{if2.busy, if2.done, if2.s, if2.co, if2.ovf, if2.zero};
      default: o = '{if3.busy, if3.done, {24'd0, if3.s}, if3.co, if3.ovf, if3.zero};
    endcase
    return o;
  endfunction

  // Call at a negedge; leaves the bench at the negedge right after the accept edge.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic sub, input exp_t e, input bit push, input bit keep);
    sb_t ent;
    drive(k, 1'b1, a, b, ci, sub);
    @(negedge clk);
    if (push) begin
      ent.e   = e;
      ent.acc = cyc;
      sb_q.push_back(ent);
    end
    if (!keep) drive(k, 1'b0, a, b, ci, sub);
  endtask

  task automatic wait_done(input int k, input string name);
    obs_t o;
    sb_t  ent;
    int   busy_n = 0;
    bit   seen = 0;
    for (int i = 0; i < 200; i++) begin
      o = peek(k);
      if (o.done) begin
        seen = 1;
        break;
      end
      if (o.busy) busy_n++;
      @(negedge clk);
    end
    if (!seen) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
    end else if (sb_q.size() == 0) begin
      check({name, "_unexpected_done"}, 64'd1, 64'd0);
    end else begin
      ent = sb_q.pop_front();
      last_done = cyc;
      check({name, "_s"},       o.s,            ent.e.s);
      check({name, "_co"},      o.co,           ent.e.co);
      check({name, "_ovf"},     o.ovf,          ent.e.ovf);
      check({name, "_zero"},    o.zero,         ent.e.zero);
      check({name, "_latency"}, cyc - ent.acc,  NN[k]);
      check({name, "_busy_n"},  busy_n,         NN[k]);
      check({name, "_busy_dn"}, o.busy,         1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    obs_t        o;
    exp_t        e;
    int          d1;
    bit          seen;
    logic [31:0] ra, rb;
    logic        rci, rsub;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h00000009, 32'h00000004, 1'b1, 1'b1, 32'h00000004, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

    for (int k = 0; k < 4; k++) drive(k, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      o = peek(k);
      check($sformatf("rst%0d_busy", k), o.busy, 1'b0);
      check($sformatf("rst%0d_done", k), o.done, 1'b0);
      check($sformatf("rst%0d_s", k),    o.s,    32'd0);
      check($sformatf("rst%0d_flags", k), {o.co, o.ovf, o.zero}, 3'b000);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      e = '{vecs[i].s, vecs[i].co, vecs[i].ovf, vecs[i].zero};
      issue(0, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, e, 1'b1, 1'b0);
      wait_done(0, $sformatf("vec%0d", i));
      @(negedge clk);
      o = peek(0);
      check($sformatf("vec%0d_pulse", i), {o.busy, o.done}, 2'b00);
    end

    // start held across RUN with operands changing mid-op; re-sampled in the DONE cycle
    e = '{32'h80000000, 1'b0, 1'b1, 1'b0};
    issue(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, e, 1'b1, 1'b1);
    drive(0, 1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
    wait_done(0, "hold_x");
    d1 = last_done;
    sb_q.push_back('{'{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}, cyc + 1});
    @(negedge clk);
    drive(0, 1'b0, 32'd5, 32'd7, 1'b0, 1'b1);
    wait_done(0, "hold_y");
    check("b2b_spacing", last_done - d1, 9);
    @(negedge clk);
    o = peek(0);
    check("b2b_idle", {o.busy, o.done}, 2'b00);

    // reset in the middle of an op aborts it
    issue(0, 32'd9, 32'd4, 1'b1, 1'b1, '{32'd4, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b0);
    wait_done(0, "pre_abort");
    @(negedge clk);
    issue(0, 32'h12345678, 32'h00000001, 1'b0, 1'b0, e, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    o = peek(0);
    check("abort_busy", o.busy, 1'b0);
    check("abort_done", o.done, 1'b0);
    check("abort_s",    o.s,    32'd0);
    check("abort_co",   o.co,   1'b0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (peek(0).done) seen = 1;
    end
    check("abort_no_done", seen, 1'b0);
    issue(0, 32'h12345678, 32'h11111111, 1'b1, 1'b0, '{32'h2345678A, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    wait_done(0, "post_abort");

    // random ops on every geometry against the reference model
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        ra   = (i == 0) ? 32'hFFFFFFFF : $urandom;
        rb   = (i == 0) ? 32'h00000000 : $urandom;
        rci  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rsub = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        issue(k, ra, rb, rci, rsub, model(WW[k], ra, rb, rci, rsub), 1'b1, 1'b0);
        wait_done(k, $sformatf("rnd_k%0d_%0d", k, i));
      end
    end

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_seq_chunked.md
Name: adder_seq_chunked

Overview:
- Parametrised multi-cycle ripple-carry adder/subtractor for WIDTH-bit operands.
- Processes one CHUNK-bit slice per clock, LSB slice first, holding the inter-slice carry in a register.
- Trades latency for a short combinational path.
- Used by the datapath where a full-width single-cycle ripple adder would limit clock frequency; reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 4, bits added per cycle. Must divide WIDTH exactly; N = WIDTH/CHUNK slices.

Ports:
- clk    input   1      rising-edge clock
- reset  input   1      synchronous, active-high reset
- start  input   1      request; sampled only when not busy
- a      input   WIDTH  operand A, sampled on the accepting edge
- b      input   WIDTH  operand B, sampled on the accepting edge
- ci     input   1      carry-in (add) / borrow-in (sub), sampled on the accepting edge
- sub    input   1      0 = add, 1 = subtract, sampled on the accepting edge
- busy   output  1      high while slices are being computed
- done   output  1      one-cycle pulse: results valid
- s      output  WIDTH  result
- co     output  1      carry-out of MSB slice
- ovf    output  1      signed two's-complement overflow
- zero   output  1      s == 0

Behaviour:
- One clock; synchronous active-high reset; all state changes on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, s=0, co=0, ovf=0, zero=0; internal carry=0, slice index=0. Reset has priority over every other event.
- States: IDLE, RUN, DONE.
- Accept: on an edge with start=1 and state IDLE or DONE:
  - Latch a, b_eff = sub ? ~b : b, and carry = sub ? ~ci : ci.
  - Clear index and s; state -> RUN; busy=1.
  - Net operation: add gives a+b+ci; sub gives a-b-ci.
- start=1 while in RUN is ignored. The bench does not need to hold start; no queueing.
- RUN, each edge:
  - s[idx*CHUNK +: CHUNK] <= slice sum of a, b_eff and carry.
  - carry <= slice carry-out; idx <= idx+1.
  - When idx == N-1 this edge also sets co = final carry-out, ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), zero = (full result == 0); state -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle. Next edge goes to RUN if start=1 (back-to-back accepted), else IDLE.
- Latency: accept edge at cycle 0 -> done high during cycle N (N edges of RUN). Throughput: one op per N+1 cycles with back-to-back start.
- Output hold: s/co/ovf/zero hold from the DONE cycle until the next accept edge. During RUN, s is partial and co/ovf/zero keep previous values; they are not to be consumed until done.
- Sub flags: co=1 means no borrow (e.g. 7-5 -> co=1; 5-7 -> co=0).
- Wrap-around: results are modulo 2^WIDTH; carry beyond the MSB appears only on co.
- N=1 (CHUNK=WIDTH) is legal: one RUN cycle, done at cycle 1.
- Reset mid-RUN aborts the operation: next cycle IDLE, busy=0, done=0, s=0, no done pulse for the aborted op.
- Operand changes after the accept edge have no effect.

Test Plan (WIDTH=32, CHUNK=4, N=8 unless noted):
- Add wrap: a=0xFFFFFFFF, b=1, ci=0, sub=0, start pulse -> busy for 8 cycles, done pulse in cycle 8, s=0x00000000, co=1, ovf=0, zero=1.
- Signed overflow add: a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1, zero=0. Then a=0x12345678, b=0x11111111, ci=1 -> s=0x2345678A, co=0, ovf=0.
- Subtract: a=5, b=7, ci=0, sub=1 -> s=0xFFFFFFFE, co=0, ovf=0. Then a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, co=1, ovf=1. Then a=9, b=4, ci=1, sub=1 -> s=4, co=1.
- Handshake:
  - start held high across RUN -> exactly one op per accept; start re-sampled in the DONE cycle.
  - Back-to-back ops give done pulses 9 cycles apart.
  - Changing a/b mid-RUN does not alter the result.
- Reset mid-op: assert reset at RUN cycle 4 -> next cycle busy=0, done=0, s=0, co=0. No done pulse follows. A new start afterwards computes correctly.
- Parameter sweep: CHUNK=32 (N=1), CHUNK=1 (N=32), WIDTH=8/CHUNK=2. Random a/b/ci/sub compared against a+b+ci / a-b-ci reference with flags; done latency = N in each.
